// File: rtl/uart_cmd_framer_if.sv
// Byte stream from the UART receiver into the command framer, plus the
// framed register-command strobes it produces.
interface uart_cmd_framer_if #(
  parameter int ADDR_W = 6
);
  // receiver side
  logic [7:0]        rx_data;
  logic              rx_data_ready;
  logic              rx_data_error;
  logic              rx_endofpacket;
  logic              rx_idle;
  // command side
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_bytecnt;
  logic [7:0]        reg_wrdata;
  logic              reg_wr;
  logic              rd_req;
  logic [7:0]        rd_len;
  logic              frame_done;
  logic              frame_err;
  logic [2:0]        err_code;
  logic              busy;

  // environment / receiver view: drives the byte stream, watches commands
  modport master (
    output rx_data, rx_data_ready, rx_data_error, rx_endofpacket, rx_idle,
    input  reg_addr, reg_bytecnt, reg_wrdata, reg_wr, rd_req, rd_len,
           frame_done, frame_err, err_code, busy
  );

  // framer view
  modport slave (
    input  rx_data, rx_data_ready, rx_data_error, rx_endofpacket, rx_idle,
    output reg_addr, reg_bytecnt, reg_wrdata, reg_wr, rd_req, rd_len,
           frame_done, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// UART command framer: parses HDR, LEN, DATA[], CSUM frames from the RX byte
// stream into write strobes and read requests. The receiver cannot be
// stalled, so every byte is consumed in the cycle it arrives and every
// output is a one-cycle registered strobe.
module uart_cmd_framer #(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6
) (
  input logic              clk,
  input logic              reset_n,
  uart_cmd_framer_if.slave bus
);

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrFraming  = 3'd1;
  localparam logic [2:0] ErrTimeout  = 3'd2;
  localparam logic [2:0] ErrLength   = 3'd3;
  localparam logic [2:0] ErrChecksum = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DISCARD
  } state_t;

  state_t            state;
  logic              isWrite;
  logic [7:0]        lenReg;
  logic [7:0]        count;
  logic [7:0]        acc;

  logic [ADDR_W-1:0] addrReg;
  logic [7:0]        bytecntReg;
  logic [7:0]        wrdataReg;
  logic              wrReg;
  logic              rdReqReg;
  logic [7:0]        rdLenReg;
  logic              doneReg;
  logic              errReg;
  logic [2:0]        errCodeReg;

  logic              lenTooBig;
  logic              lastData;

  assign lenTooBig = (bus.rx_data > 8'(MAX_LEN));
  // count is the index of the byte now arriving; LEN >= 1 whenever in DATA
  assign lastData  = (count == (lenReg - 8'd1));

  // Frame parser: one byte per rx_data_ready, errors abort, strobes self-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      isWrite    <= 1'b0;
      lenReg     <= '0;
      count      <= '0;
      acc        <= '0;
      addrReg    <= '0;
      bytecntReg <= '0;
      wrdataReg  <= '0;
      wrReg      <= 1'b0;
      rdReqReg   <= 1'b0;
      rdLenReg   <= '0;
      doneReg    <= 1'b0;
      errReg     <= 1'b0;
      errCodeReg <= ErrNone;
    end else begin
      wrReg    <= 1'b0;
      rdReqReg <= 1'b0;
      doneReg  <= 1'b0;
      errReg   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.rx_data_error) begin
            errReg     <= 1'b1;
            errCodeReg <= ErrFraming;
            state      <= DISCARD;
          end else if (bus.rx_data_ready) begin
            addrReg    <= bus.rx_data[ADDR_W-1:0];
            isWrite    <= bus.rx_data[7];
            acc        <= bus.rx_data;
            count      <= '0;
            errCodeReg <= ErrNone;
            state      <= LEN;
          end
        end

        // Wait for the line to go quiet before trusting the next byte as HDR
        DISCARD: begin
          if (bus.rx_idle && !bus.rx_data_ready) begin
            state <= IDLE;
          end
        end

        LEN, DATA, CSUM: begin
          if (bus.rx_data_error) begin
            errReg     <= 1'b1;
            errCodeReg <= ErrFraming;
            state      <= DISCARD;
          end else if (bus.rx_data_ready) begin
            acc <= acc ^ bus.rx_data;
            unique case (state)
              LEN: begin
                lenReg <= bus.rx_data;
                if (lenTooBig || (!isWrite && bus.rx_data == 8'd0)) begin
                  errReg     <= 1'b1;
                  errCodeReg <= ErrLength;
                  state      <= DISCARD;
                end else if (isWrite && bus.rx_data != 8'd0) begin
                  state <= DATA;
                end else begin
                  state <= CSUM;
                end
              end
              DATA: begin
                wrdataReg  <= bus.rx_data;
                bytecntReg <= count;
                wrReg      <= 1'b1;
                count      <= count + 8'd1;
                if (lastData) begin
                  state <= CSUM;
                end
              end
              CSUM: begin
                if (bus.rx_data == acc) begin
                  doneReg <= 1'b1;
                  if (!isWrite) begin
                    rdReqReg <= 1'b1;
                    rdLenReg <= lenReg;
                  end
                end else begin
                  errReg     <= 1'b1;
                  errCodeReg <= ErrChecksum;
                end
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end else if (bus.rx_endofpacket) begin
            // gap inside a frame: line is already idle, no discard needed
            errReg     <= 1'b1;
            errCodeReg <= ErrTimeout;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.reg_addr    = addrReg;
  assign bus.reg_bytecnt = bytecntReg;
  assign bus.reg_wrdata  = wrdataReg;
  assign bus.reg_wr      = wrReg;
  assign bus.rd_req      = rdReqReg;
  assign bus.rd_len      = rdLenReg;
  assign bus.frame_done  = doneReg;
  assign bus.frame_err   = errReg;
  assign bus.err_code    = errCodeReg;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: frame-level stimulus generator that knows what
// each frame should produce, a per-cycle output checker, and a few directed
// frames with hand-computed results.
module tb_uart_cmd_framer;
  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_framer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_cmd_framer #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // expected outputs after the coming clock edge
  bit                expWr, expDone, expErr, expRd;
  logic [7:0]        expWrData, expCnt, expRdLen;
  logic [2:0]        mErrCode = 3'd0;
  logic [ADDR_W-1:0] mAddr = '0;
  bit                mBusy = 1'b0;
  bit                mDiscard = 1'b0;

  int nChecks = 0;
  int nPass = 0;
  int obsWr = 0, obsDone = 0, obsErr = 0, obsRd = 0;
  logic [ADDR_W-1:0] lastRdAddr;
  logic [7:0]        lastRdLen;
  logic [23:0]       wrLog[$];
  logic [7:0]        frameData[$];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // per-cycle compare against the expectation set for this edge
  always @(posedge clk) begin
    #1;
    chk("reg_wr", int'(bus.reg_wr), int'(expWr));
    chk("frame_done", int'(bus.frame_done), int'(expDone));
    chk("frame_err", int'(bus.frame_err), int'(expErr));
    chk("rd_req", int'(bus.rd_req), int'(expRd));
    chk("err_code", int'(bus.err_code), int'(mErrCode));
    chk("busy", int'(bus.busy), int'(mBusy));
    chk("reg_addr", int'(bus.reg_addr), int'(mAddr));
    if (expWr) begin
      chk("reg_wrdata", int'(bus.reg_wrdata), int'(expWrData));
      chk("reg_bytecnt", int'(bus.reg_bytecnt), int'(expCnt));
    end
    if (expRd) chk("rd_len", int'(bus.rd_len), int'(expRdLen));
    if (bus.reg_wr) begin
      obsWr++;
      wrLog.push_back({2'b00, bus.reg_addr, bus.reg_bytecnt, bus.reg_wrdata});
    end
    if (bus.frame_done) obsDone++;
    if (bus.frame_err) obsErr++;
    if (bus.rd_req) begin
      obsRd++;
      lastRdAddr = bus.reg_addr;
      lastRdLen  = bus.rd_len;
    end
  end

  // drive one cycle of receiver activity; clears the strobe expectations
  task automatic cyc(input bit rdy, input bit derr, input bit eop, input bit idl,
                     input logic [7:0] d);
    @(negedge clk);
    bus.rx_data_ready  = rdy;
    bus.rx_data_error  = derr;
    bus.rx_endofpacket = eop;
    bus.rx_idle        = idl;
    bus.rx_data        = d;
    expWr   = 1'b0;
    expDone = 1'b0;
    expErr  = 1'b0;
    expRd   = 1'b0;
  endtask

  // send HDR, LEN, frameData, CSUM (CSUM only for a legal length); abortKind
  // 1 replaces byte abortPos by a framing error, 2 by an end-of-packet gap
  task automatic sendFrame(input logic [7:0] hdr, input logic [7:0] len,
                           input logic [7:0] csum, input int abortKind,
                           input int abortPos);
    logic [7:0] s[$];
    logic [7:0] x;
    logic [7:0] b;
    bit wr, legal, skip;
    int nd, nt;
    wr    = hdr[7];
    legal = (int'(len) <= MAX_LEN) && (wr || len != 8'd0);
    s.push_back(hdr);
    s.push_back(len);
    foreach (frameData[i]) s.push_back(frameData[i]);
    if (legal) s.push_back(csum);
    nd   = (legal && wr) ? int'(len) : 0;
    x    = 8'h00;
    skip = 1'b0;
    $display("frame hdr=%02h len=%0d csum=%02h nbytes=%0d abort=%0d@%0d",
             hdr, len, csum, s.size(), abortKind, abortPos);
    for (int i = 0; i < s.size(); i++) begin
      b = s[i];
      if (i > 0) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
      if (abortKind == 1 && i == abortPos) begin
        cyc(bit'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, b);
        expErr = 1'b1; mErrCode = 3'd1; mBusy = 1'b1; mDiscard = 1'b1; skip = 1'b1;
      end else if (abortKind == 2 && i == abortPos) begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        expErr = 1'b1; mErrCode = 3'd2; mBusy = 1'b0;
        break;
      end else begin
        cyc(1'b1, 1'b0, bit'($urandom_range(0, 7) == 0), 1'b0, b);
        if (skip) begin
          // byte lands while discarding: no effect
        end else if (i == 0) begin
          mAddr = b[ADDR_W-1:0]; mErrCode = 3'd0; mBusy = 1'b1;
        end else if (i == 1) begin
          if (!legal) begin
            expErr = 1'b1; mErrCode = 3'd3; mDiscard = 1'b1; skip = 1'b1;
          end
        end else if (i < 2 + nd) begin
          expWr = 1'b1; expWrData = b; expCnt = 8'(i - 2);
        end else begin
          if (b == x) begin
            expDone = 1'b1;
            if (!wr) begin expRd = 1'b1; expRdLen = len; end
          end else begin
            expErr = 1'b1; mErrCode = 3'd4;
          end
          mBusy = 1'b0;
        end
        x = x ^ b;
      end
    end
    nt = int'($urandom_range(2, 4));
    for (int t = 0; t < nt; t++) begin
      cyc(1'b0, 1'b0, bit'($urandom_range(0, 3) == 0), 1'b1, 8'($urandom));
      if (mDiscard) begin mBusy = 1'b0; mDiscard = 1'b0; end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.rx_data_ready  = 1'b0;
    bus.rx_data_error  = 1'b0;
    bus.rx_endofpacket = 1'b0;
    bus.rx_idle        = 1'b1;
    expWr = 1'b0; expDone = 1'b0; expErr = 1'b0; expRd = 1'b0;
    mErrCode = 3'd0; mAddr = '0; mBusy = 1'b0; mDiscard = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_reg_addr", int'(bus.reg_addr), 0);
    chk("rst_err_code", int'(bus.err_code), 0);
    chk("rst_reg_wr", int'(bus.reg_wr), 0);
    chk("rst_rd_req", int'(bus.rd_req), 0);
    chk("rst_rd_len", int'(bus.rd_len), 0);
    chk("rst_wrdata", int'(bus.reg_wrdata), 0);
    chk("rst_bytecnt", int'(bus.reg_bytecnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int b0, d0, e0, r0, w0;
    logic [23:0] ent;
    logic [7:0] hdr, len, csum, x;
    bit wr, legal;
    int r, nb, ak, ap;

    bus.rx_data_ready  = 1'b0;
    bus.rx_data_error  = 1'b0;
    bus.rx_endofpacket = 1'b0;
    bus.rx_idle        = 1'b1;
    bus.rx_data        = 8'h00;
    expWr = 1'b0; expDone = 1'b0; expErr = 1'b0; expRd = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // write to address 5: two strobes then frame_done
    frameData = {8'hAA, 8'h55};
    b0 = wrLog.size(); d0 = obsDone;
    sendFrame(8'h85, 8'h02, 8'h78, 0, 0);
    chk("tp_wr_count", wrLog.size() - b0, 2);
    ent = (wrLog.size() > b0) ? wrLog[b0] : 24'h0;
    chk("tp_wr_first", int'(ent), 24'h0500AA);
    ent = (wrLog.size() > b0 + 1) ? wrLog[b0 + 1] : 24'h0;
    chk("tp_wr_second", int'(ent), 24'h050155);
    chk("tp_wr_done", obsDone - d0, 1);
    chk("tp_wr_err_code", int'(bus.err_code), 0);
    chk("tp_wr_busy", int'(bus.busy), 0);

    // read of 4 bytes at 0x10
    frameData.delete();
    r0 = obsRd; w0 = obsWr; d0 = obsDone;
    sendFrame(8'h10, 8'h04, 8'h14, 0, 0);
    chk("tp_rd_count", obsRd - r0, 1);
    chk("tp_rd_addr", int'(lastRdAddr), 8'h10);
    chk("tp_rd_len", int'(lastRdLen), 4);
    chk("tp_rd_no_wr", obsWr - w0, 0);
    chk("tp_rd_done", obsDone - d0, 1);

    // bad checksum keeps its one write, then a clean empty write frame
    frameData = {8'h11};
    w0 = obsWr; e0 = obsErr;
    sendFrame(8'h85, 8'h01, 8'h00, 0, 0);
    chk("tp_cs_wr_count", obsWr - w0, 1);
    ent = (wrLog.size() > 0) ? wrLog[wrLog.size() - 1] : 24'h0;
    chk("tp_cs_wr_data", int'(ent[7:0]), 8'h11);
    chk("tp_cs_err", obsErr - e0, 1);
    chk("tp_cs_err_code", int'(bus.err_code), 4);
    frameData.delete();
    d0 = obsDone;
    sendFrame(8'h81, 8'h00, 8'h81, 0, 0);
    chk("tp_cs_next_done", obsDone - d0, 1);
    chk("tp_cs_next_code", int'(bus.err_code), 0);

    // length 0x41 > MAX_LEN, three trailing bytes ignored
    frameData = {8'h01, 8'h02, 8'h03};
    w0 = obsWr; e0 = obsErr;
    sendFrame(8'h81, 8'h41, 8'h00, 0, 0);
    chk("tp_len_code", int'(bus.err_code), 3);
    chk("tp_len_no_wr", obsWr - w0, 0);
    chk("tp_len_err", obsErr - e0, 1);
    chk("tp_len_busy", int'(bus.busy), 0);

    // end-of-packet after the first data byte
    frameData = {8'h01, 8'h02, 8'h03};
    sendFrame(8'h81, 8'h03, 8'h81, 2, 3);
    chk("tp_to_code", int'(bus.err_code), 2);
    chk("tp_to_busy", int'(bus.busy), 0);

    // framing error on the third data byte, then a valid frame
    frameData = {8'h01, 8'h02, 8'h03};
    sendFrame(8'h81, 8'h03, 8'h81, 1, 4);
    chk("tp_fe_code", int'(bus.err_code), 1);
    chk("tp_fe_busy", int'(bus.busy), 0);
    frameData.delete();
    d0 = obsDone;
    sendFrame(8'h81, 8'h00, 8'h81, 0, 0);
    chk("tp_fe_next_done", obsDone - d0, 1);

    // reset mid-frame, then a read is accepted as a fresh frame
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h85);
    mAddr = 6'd5; mErrCode = 3'd0; mBusy = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    doReset();
    frameData.delete();
    r0 = obsRd; w0 = obsWr;
    sendFrame(8'h10, 8'h04, 8'h14, 0, 0);
    chk("tp_rst_rd", obsRd - r0, 1);
    chk("tp_rst_rd_len", int'(lastRdLen), 4);
    chk("tp_rst_no_wr", obsWr - w0, 0);

    // randomized frames
    for (int f = 0; f < 300; f++) begin
      wr  = bit'($urandom_range(0, 1));
      hdr = {wr, 7'($urandom)};
      r   = int'($urandom_range(0, 9));
      if (r < 6)       len = 8'($urandom_range(0, 6));
      else if (r == 6) len = 8'(MAX_LEN);
      else if (r == 7) len = 8'($urandom_range(MAX_LEN + 1, 255));
      else             len = 8'($urandom_range(0, 3));
      legal = (int'(len) <= MAX_LEN) && (wr || len != 8'd0);
      frameData.delete();
      if (legal && wr) repeat (len) frameData.push_back(8'($urandom));
      else if (!legal) repeat ($urandom_range(0, 3)) frameData.push_back(8'($urandom));
      x = hdr ^ len;
      foreach (frameData[i]) x = x ^ frameData[i];
      csum = x;
      if ($urandom_range(0, 5) == 0) csum = csum ^ 8'($urandom_range(1, 255));
      nb = 3 + ((legal && wr) ? int'(len) : 0);
      ak = 0; ap = 0;
      if (legal) begin
        r = int'($urandom_range(0, 11));
        if (r < 2) begin
          ak = 1; ap = int'($urandom_range(0, nb - 1));
        end else if (r < 4) begin
          ak = 2; ap = int'($urandom_range(1, nb - 1));
        end
      end
      sendFrame(hdr, len, csum, ak, ap);
    end

    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
